// File: rtl/sparc_mpu_if.sv
// Observation bundle of the sparc_mpu core: FSM state, instruction register and MAR.
// The core drives it through the master modport; observers use the slave modport.
interface sparc_mpu_if;
    logic [6:0]  State;
    logic [31:0] IROut;
    logic [31:0] MAROut;

    modport master (output State, output IROut, output MAROut);
    modport slave  (input  State, input  IROut, input  MAROut);
endinterface

// File: rtl/sparc_mpu.sv
// Multicycle SPARC-V8-subset CPU: control FSM, datapath, flat 32x32 register file
// and an internal big-endian byte-addressed RAM that is preloaded externally.
module sparc_mpu #(
    parameter int          MEM_BYTES = 512,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic       Clk,
    input  logic       Clr,
    sparc_mpu_if.master bus
);
    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [6:0] S_RESET  = 7'd0,  S_FETCH1 = 7'd1,  S_FETCH2 = 7'd2;
    localparam logic [6:0] S_FETCH3 = 7'd3,  S_DECODE = 7'd4,  S_ALU    = 7'd10;
    localparam logic [6:0] S_SETHI  = 7'd20, S_BRANCH = 7'd30, S_LD1    = 7'd40;
    localparam logic [6:0] S_LD2    = 7'd41, S_LD3    = 7'd42, S_ST1    = 7'd50;
    localparam logic [6:0] S_ST2    = 7'd51, S_HALT   = 7'd127;

    logic [6:0]    state_r, next_state_s;
    logic [31:0]   pc_r, npc_r, cpc_r, ir_r, mdr_r;
    logic [AW-1:0] mar_r;
    logic [3:0]    icc_r;              // {N, Z, V, C}
    logic [31:0]   regs_r [32];
    logic [7:0]    mem_r [MEM_BYTES];

    logic [1:0]  op_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  op2f_s;
    logic [5:0]  op3_s;
    logic [3:0]  cond_s;
    logic [31:0] rs1_val_s, op2_val_s, rd_val_s, mem_word_s, br_target_s;
    logic [AW-1:0] ea_s, wa_s;
    logic [32:0] add_s, sub_s;
    logic [31:0] alu_res_s;
    logic        alu_v_s, alu_c_s, alu_valid_s, cond_valid_s, taken_s;

    logic        mar_pc_s, mar_ea_s, mdr_mem_s, mdr_rd_s, ir_ld_s, pc_adv_s;
    logic        rd_we_s, icc_we_s, npc_br_s, mem_we_s;
    logic [31:0] rd_data_s;
    logic        unused_s;

    assign op_s        = ir_r[31:30];
    assign rd_s        = ir_r[29:25];
    assign cond_s      = ir_r[28:25];
    assign op2f_s      = ir_r[24:22];
    assign op3_s       = ir_r[24:19];
    assign rs1_s       = ir_r[18:14];
    assign rs2_s       = ir_r[4:0];
    assign rs1_val_s   = regs_r[rs1_s];
    assign rd_val_s    = regs_r[rd_s];
    assign op2_val_s   = ir_r[13] ? {{19{ir_r[12]}}, ir_r[12:0]} : regs_r[rs2_s];
    assign ea_s        = rs1_val_s[AW-1:0] + op2_val_s[AW-1:0];
    assign wa_s        = {mar_r[AW-1:2], 2'b00};
    assign mem_word_s  = {mem_r[wa_s], mem_r[{mar_r[AW-1:2], 2'b01}],
                          mem_r[{mar_r[AW-1:2], 2'b10}], mem_r[{mar_r[AW-1:2], 2'b11}]};
    assign br_target_s = cpc_r + {{8{ir_r[21]}}, ir_r[21:0], 2'b00};
    assign add_s       = {1'b0, rs1_val_s} + {1'b0, op2_val_s};
    assign sub_s       = {1'b0, rs1_val_s} - {1'b0, op2_val_s};
    assign unused_s    = ^icc_r[1:0];

    // ALU result and flag candidates for the current op3
    always_comb begin
        alu_res_s   = 32'd0;
        alu_v_s     = 1'b0;
        alu_c_s     = 1'b0;
        alu_valid_s = 1'b1;
        case (op3_s)
            6'b000000, 6'b010000: begin
                alu_res_s = add_s[31:0];
                alu_c_s   = add_s[32];
                alu_v_s   = (rs1_val_s[31] == op2_val_s[31]) && (add_s[31] != rs1_val_s[31]);
            end
            6'b000001, 6'b010001: alu_res_s = rs1_val_s & op2_val_s;
            6'b000010, 6'b010010: alu_res_s = rs1_val_s | op2_val_s;
            6'b000011, 6'b010011: alu_res_s = rs1_val_s ^ op2_val_s;
            6'b000100, 6'b010100: begin
                alu_res_s = sub_s[31:0];
                alu_c_s   = sub_s[32];
                alu_v_s   = (rs1_val_s[31] != op2_val_s[31]) && (sub_s[31] != rs1_val_s[31]);
            end
            6'b100101: alu_res_s = rs1_val_s << op2_val_s[4:0];
            6'b100110: alu_res_s = rs1_val_s >> op2_val_s[4:0];
            6'b100111: alu_res_s = 32'($signed(rs1_val_s) >>> op2_val_s[4:0]);
            default:   alu_valid_s = 1'b0;
        endcase
    end

    // Branch condition legality and outcome against the current icc
    always_comb begin
        cond_valid_s = 1'b1;
        taken_s      = 1'b0;
        case (cond_s)
            4'b1000: taken_s = 1'b1;
            4'b0000: taken_s = 1'b0;
            4'b0001: taken_s = icc_r[2];
            4'b1001: taken_s = ~icc_r[2];
            4'b0110: taken_s = icc_r[3];
            4'b1110: taken_s = ~icc_r[3];
            default: cond_valid_s = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Clr) state_r <= S_RESET;
        else     state_r <= next_state_s;
    end

    // FSM next-state logic; anything not decodable ends in HALT
    always_comb begin
        next_state_s = S_HALT;
        case (state_r)
            S_RESET:  next_state_s = S_FETCH1;
            S_FETCH1: next_state_s = S_FETCH2;
            S_FETCH2: next_state_s = S_FETCH3;
            S_FETCH3: next_state_s = S_DECODE;
            S_DECODE: begin
                case (op_s)
                    2'b00: begin
                        if (op2f_s == 3'b100)                      next_state_s = S_SETHI;
                        else if (op2f_s == 3'b010 && cond_valid_s) next_state_s = S_BRANCH;
                        else                                       next_state_s = S_HALT;
                    end
                    2'b10: next_state_s = alu_valid_s ? S_ALU : S_HALT;
                    2'b11: begin
                        if (op3_s == 6'b000000)      next_state_s = S_LD1;
                        else if (op3_s == 6'b000100) next_state_s = S_ST1;
                        else                         next_state_s = S_HALT;
                    end
                    default: next_state_s = S_HALT;
                endcase
            end
            S_ALU, S_SETHI, S_BRANCH, S_LD3, S_ST2: next_state_s = S_FETCH1;
            S_LD1:   next_state_s = S_LD2;
            S_LD2:   next_state_s = S_LD3;
            S_ST1:   next_state_s = S_ST2;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_HALT;
        endcase
    end

    // FSM outputs: datapath load enables per state
    always_comb begin
        mar_pc_s  = 1'b0; mar_ea_s = 1'b0; mdr_mem_s = 1'b0; mdr_rd_s = 1'b0;
        ir_ld_s   = 1'b0; pc_adv_s = 1'b0; rd_we_s   = 1'b0; icc_we_s = 1'b0;
        npc_br_s  = 1'b0; mem_we_s = 1'b0; rd_data_s = 32'd0;
        case (state_r)
            S_FETCH1: mar_pc_s  = 1'b1;
            S_FETCH2: mdr_mem_s = 1'b1;
            S_FETCH3: begin ir_ld_s = 1'b1; pc_adv_s = 1'b1; end
            // MAR takes the effective address already on dispatch so it is visible in LD1/ST1
            S_DECODE: mar_ea_s = (next_state_s == S_LD1) || (next_state_s == S_ST1);
            S_ALU:    begin rd_we_s = 1'b1; rd_data_s = alu_res_s; icc_we_s = op3_s[4]; end
            S_SETHI:  begin rd_we_s = 1'b1; rd_data_s = {ir_r[21:0], 10'd0}; end
            S_BRANCH: npc_br_s = taken_s;
            S_LD1:    mar_ea_s  = 1'b1;
            S_LD2:    mdr_mem_s = 1'b1;
            S_LD3:    begin rd_we_s = 1'b1; rd_data_s = mdr_r; end
            S_ST1:    begin mar_ea_s = 1'b1; mdr_rd_s = 1'b1; end
            S_ST2:    mem_we_s = 1'b1;
            default:  rd_data_s = 32'd0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (Clr) begin
            pc_r  <= RESET_PC;
            npc_r <= RESET_PC + 32'd4;
            cpc_r <= 32'd0;
            ir_r  <= 32'd0;
            mdr_r <= 32'd0;
            mar_r <= '0;
            icc_r <= 4'd0;
        end else begin
            if (mar_pc_s)      mar_r <= pc_r[AW-1:0];
            else if (mar_ea_s) mar_r <= ea_s;
            if (mdr_mem_s)     mdr_r <= mem_word_s;
            else if (mdr_rd_s) mdr_r <= rd_val_s;
            if (ir_ld_s)       ir_r  <= mdr_r;
            if (pc_adv_s) begin
                cpc_r <= pc_r;
                pc_r  <= npc_r;
                npc_r <= npc_r + 32'd4;
            end else if (npc_br_s) begin
                npc_r <= br_target_s;
            end
            if (icc_we_s) icc_r <= {alu_res_s[31], (alu_res_s == 32'd0), alu_v_s, alu_c_s};
        end
    end

    // Register file; r0 is never written so it always reads zero
    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
        end else if (rd_we_s && (rd_s != 5'd0)) begin
            regs_r[rd_s] <= rd_data_s;
        end
    end

    // RAM store port; reset only blocks a pending store, contents are kept
    always_ff @(posedge Clk) begin
        if (!Clr && mem_we_s) begin
            mem_r[wa_s]                    <= mdr_r[31:24];
            mem_r[{mar_r[AW-1:2], 2'b01}]  <= mdr_r[23:16];
            mem_r[{mar_r[AW-1:2], 2'b10}]  <= mdr_r[15:8];
            mem_r[{mar_r[AW-1:2], 2'b11}]  <= mdr_r[7:0];
        end
    end

    assign bus.State  = state_r;
    assign bus.IROut  = ir_r;
    assign bus.MAROut = {{(32-AW){1'b0}}, mar_r};
endmodule

// File: tb/tb_sparc_mpu.sv
// Scoreboard bench for sparc_mpu: each program queues its expected state/MAR trace,
// which is popped and compared cycle by cycle; architectural results checked at the end.
module tb_sparc_mpu;
    logic Clk;
    logic Clr;
    sparc_mpu_if bus ();

    sparc_mpu #(.MEM_BYTES(512), .RESET_PC(32'd0)) dut (.Clk(Clk), .Clr(Clr), .bus(bus));

    typedef struct {
        logic [6:0]  st;
        bit          chk_mar;
        logic [31:0] mar;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam int C_ALU = 0, C_SETHI = 1, C_BR = 2, C_LD = 3, C_ST = 4, C_HALT = 5;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_st(input logic [6:0] st, input bit cm, input logic [31:0] m);
        exp_t e;
        e.st = st; e.chk_mar = cm; e.mar = m;
        exp_q.push_back(e);
    endtask

    // Expected state trace of one executed instruction
    task automatic push_ins(input int cls, input logic [31:0] ea);
        push_st(7'd1, 1'b0, 32'd0);
        push_st(7'd2, 1'b0, 32'd0);
        push_st(7'd3, 1'b0, 32'd0);
        push_st(7'd4, 1'b0, 32'd0);
        case (cls)
            C_ALU:   push_st(7'd10, 1'b0, 32'd0);
            C_SETHI: push_st(7'd20, 1'b0, 32'd0);
            C_BR:    push_st(7'd30, 1'b0, 32'd0);
            C_LD: begin
                push_st(7'd40, 1'b1, ea); push_st(7'd41, 1'b1, ea); push_st(7'd42, 1'b1, ea);
            end
            C_ST: begin
                push_st(7'd50, 1'b1, ea); push_st(7'd51, 1'b1, ea);
            end
            default: push_st(7'd127, 1'b0, 32'd0);
        endcase
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) dut.mem_r[i] = 8'h00;
    endtask

    task automatic load_word(input int a, input logic [31:0] w);
        dut.mem_r[a]     = w[31:24];
        dut.mem_r[a + 1] = w[23:16];
        dut.mem_r[a + 2] = w[15:8];
        dut.mem_r[a + 3] = w[7:0];
    endtask

    function automatic logic [31:0] ram_word(input int a);
        return {dut.mem_r[a], dut.mem_r[a + 1], dut.mem_r[a + 2], dut.mem_r[a + 3]};
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
        check_eq("rst_state", {25'd0, bus.State}, 32'd0);
        check_eq("rst_mar", bus.MAROut, 32'd0);
        check_eq("rst_ir", bus.IROut, 32'd0);
        Clr = 1'b0;
    endtask

    // Pops one expectation per cycle; bounded by the queue length
    task automatic run_trace(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            @(negedge Clk);
            e = exp_q.pop_front();
            check_eq({tag, "_state"}, {25'd0, bus.State}, {25'd0, e.st});
            if (e.chk_mar) check_eq({tag, "_mar"}, bus.MAROut, e.mar);
        end
    endtask

    task automatic check_halted(input string tag);
        repeat (2) @(negedge Clk);
        check_eq({tag, "_halt"}, {25'd0, bus.State}, 32'd127);
        check_eq({tag, "_ir"}, bus.IROut, 32'd0);
    endtask

    task automatic load_branch_prog(input logic [31:0] br);
        clear_mem();
        load_word(0,  32'h82102005);   // or   %g0,5,%g1
        load_word(4,  32'h80A04001);   // subcc %g1,%g1,%g0
        load_word(8,  br);             // be/bne +3
        load_word(12, 32'h84102009);   // or   %g0,9,%g2 (delay slot)
        load_word(16, 32'h86102001);   // or   %g0,1,%g3
        load_word(20, 32'h88102004);   // or   %g0,4,%g4
        load_word(24, 32'h00000000);
    endtask

    initial begin
        Clr = 1'b1;
        repeat (2) @(negedge Clk);

        // ALU + store
        clear_mem();
        load_word(0,  32'h82102005);
        load_word(4,  32'h84004001);
        load_word(8,  32'hC4202040);
        load_word(12, 32'h00000000);
        push_ins(C_ALU, 32'd0); push_ins(C_ALU, 32'd0);
        push_ins(C_ST, 32'h40); push_ins(C_HALT, 32'd0);
        do_reset();
        run_trace("st");
        check_eq("st_r1", dut.regs_r[1], 32'd5);
        check_eq("st_r2", dut.regs_r[2], 32'd10);
        check_eq("st_ram", ram_word(32'h40), 32'h0000000A);
        check_halted("st");

        // Load
        clear_mem();
        load_word(0,    32'hC6002080);  // ld [%g0+0x80],%g3
        load_word(4,    32'h00000000);
        load_word(32'h80, 32'hDEADBEEF);
        push_ins(C_LD, 32'h80); push_ins(C_HALT, 32'd0);
        do_reset();
        run_trace("ld");
        check_eq("ld_r3", dut.regs_r[3], 32'hDEADBEEF);
        check_halted("ld");

        // Taken branch: delay slot runs, address 16 skipped
        load_branch_prog(32'h02800003);
        push_ins(C_ALU, 32'd0); push_ins(C_ALU, 32'd0); push_ins(C_BR, 32'd0);
        push_ins(C_ALU, 32'd0); push_ins(C_ALU, 32'd0); push_ins(C_HALT, 32'd0);
        do_reset();
        run_trace("be");
        check_eq("be_r2", dut.regs_r[2], 32'd9);
        check_eq("be_r3", dut.regs_r[3], 32'd0);
        check_eq("be_r4", dut.regs_r[4], 32'd4);
        check_halted("be");

        // Untaken branch: falls through
        load_branch_prog(32'h12800003);
        push_ins(C_ALU, 32'd0); push_ins(C_ALU, 32'd0); push_ins(C_BR, 32'd0);
        push_ins(C_ALU, 32'd0); push_ins(C_ALU, 32'd0); push_ins(C_ALU, 32'd0);
        push_ins(C_HALT, 32'd0);
        do_reset();
        run_trace("bne");
        check_eq("bne_r2", dut.regs_r[2], 32'd9);
        check_eq("bne_r3", dut.regs_r[3], 32'd1);
        check_eq("bne_r4", dut.regs_r[4], 32'd4);

        // Flags from signed overflow, and discarded r0 write
        clear_mem();
        load_word(0,  32'h031FFFFF);   // sethi %hi(0x7FFFFFFF),%g1
        load_word(4,  32'h821063FF);   // or   %g1,0x3FF,%g1
        load_word(8,  32'h8A806001);   // addcc %g1,1,%g5
        load_word(12, 32'h80102007);   // or   %g0,7,%g0
        load_word(16, 32'h00000000);
        push_ins(C_SETHI, 32'd0); push_ins(C_ALU, 32'd0); push_ins(C_ALU, 32'd0);
        push_ins(C_ALU, 32'd0); push_ins(C_HALT, 32'd0);
        do_reset();
        run_trace("cc");
        check_eq("cc_r1", dut.regs_r[1], 32'h7FFFFFFF);
        check_eq("cc_r5", dut.regs_r[5], 32'h80000000);
        check_eq("cc_icc", {28'd0, dut.icc_r}, 32'hA);
        check_eq("cc_r0", dut.regs_r[0], 32'd0);

        // Reset in ST2 suppresses the store
        clear_mem();
        load_word(0,  32'h82102005);
        load_word(4,  32'h84004001);
        load_word(8,  32'hC4202040);
        load_word(12, 32'h00000000);
        load_word(32'h40, 32'hAAAAAAAA);
        push_ins(C_ALU, 32'd0); push_ins(C_ALU, 32'd0);
        push_st(7'd1, 1'b0, 32'd0); push_st(7'd2, 1'b0, 32'd0);
        push_st(7'd3, 1'b0, 32'd0); push_st(7'd4, 1'b0, 32'd0);
        push_st(7'd50, 1'b1, 32'h40); push_st(7'd51, 1'b1, 32'h40);
        do_reset();
        run_trace("mid");
        Clr = 1'b1;
        @(negedge Clk);
        check_eq("mid_state", {25'd0, bus.State}, 32'd0);
        check_eq("mid_ram", ram_word(32'h40), 32'hAAAAAAAA);
        check_eq("mid_r2", dut.regs_r[2], 32'd0);
        Clr = 1'b0;
        @(negedge Clk);
        check_eq("mid_restart", {25'd0, bus.State}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sparc_mpu.md
Name: sparc_mpu

Overview:
- Minimal multicycle SPARC‑V8‑subset microprocessor: control unit FSM, datapath (PC, nPC, CPC, MAR, MDR, IR, 32×32 register file, ALU, PSR icc) and an internal 512‑byte byte‑addressed big‑endian RAM.
- Top‑level CPU block. External observability is limited to the FSM state, the IR and the MAR.
- No memory load port: RAM is preloaded with the program by the bench, via hierarchical writes or $readmemb, before reset is released.

Parameters:
- MEM_BYTES, 512, RAM size in bytes; addresses wrap modulo MEM_BYTES.
- RESET_PC, 0, PC value after reset (nPC = RESET_PC+4).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Clr  in  1  synchronous active-high reset.
- State  out  7  current FSM state code.
- IROut  out  32  instruction register.
- MAROut  out  32  MAR, zero-extended from 9 bits.

Behaviour:
- Reset (Clr=1 at posedge):
  - State=0, PC=RESET_PC, nPC=PC+4, IR=0, MAR=0, MDR=0, icc=0, all registers=0.
  - RAM is untouched. Clr overrides any operation in progress, including mid-store.
- r0 (%g0) always reads 0; writes to it are discarded. Flat register file, no windows.
- Memory words are big-endian: byte A is bits 31:24. Word address = MAR with bits[1:0] forced to 0.
- FSM state codes and transitions (one cycle each):
  - 0 RESET -> 1.
  - 1 FETCH1: MAR<=PC -> 2.
  - 2 FETCH2: MDR<=mem word[MAR] -> 3.
  - 3 FETCH3: IR<=MDR; CPC<=PC; PC<=nPC; nPC<=nPC+4 -> 4.
  - 4 DECODE: dispatch on IR[31:30] and op2/op3 -> 10, 20, 30, 40, 50 or 127.
  - 10 ALU: rd<=result; if op3[4]=1 update icc -> 1.
  - 20 SETHI (op=00, op2=100): rd<={imm22,10'b0} -> 1. NOP = SETHI 0,%g0.
  - 30 BRANCH (op=00, op2=010): if cond true, nPC<=CPC+4*sext(disp22) -> 1.
    - Delay slot always executes; annul bit ignored.
  - 40 LD1: MAR<=rs1+op2 -> 41. 41 LD2: MDR<=mem word -> 42. 42 LD3: rd<=MDR -> 1.
  - 50 ST1: MAR<=rs1+op2; MDR<=r[rd] -> 51. 51 ST2: mem word[MAR]<=MDR -> 1.
  - 127 HALT: entered on any unsupported encoding, including 0x00000000 (UNIMP). Stays in 127 until Clr.
- op2 = i ? sext(simm13) : r[rs2]. Address arithmetic uses low 9 bits.
- ALU op3 (op=10):
  - 000000 ADD, 000001 AND, 000010 OR, 000011 XOR, 000100 SUB.
  - cc variants: 010000 ADDcc, 010001 ANDcc, 010010 ORcc, 010011 XORcc, 010100 SUBcc.
  - Shifts: 100101 SLL, 100110 SRL, 100111 SRA; count = op2[4:0].
  - Any other op3 -> 127.
- icc rules:
  - N = res[31]; Z = (res==0).
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (rs1 <u op2); V = signed overflow.
  - Logic: V=C=0.
- LD/ST op3 (op=11): 000000 LD, 000100 ST; others -> 127.
- Branch cond field:
  - 1000 BA, 0000 BN, 0001 BE (Z), 1001 BNE (!Z).
  - 0110 BNEG (N), 1110 BPOS (!N).
  - Others -> 127.
- Outputs are registered values, visible the cycle after the edge that writes them.
- Latencies: ALU/SETHI/branch = 5 cycles; ST = 6 cycles; LD = 7 cycles.

Test Plan:
- Reset: pulse Clr one cycle -> State=0, MAROut=0, IROut=0. Next edges: State 1,2,3,4.
- ALU/store: RAM = 0x82102005 (or %g0,5,%g1), 0x84004001 (add %g1,%g1,%g2), 0xC4202040 (st %g2,[0x40]), 0x00000000. Run ->
  - r1=5, r2=10.
  - MAROut=0x40 during states 50/51.
  - RAM[0x40..0x43]=00 00 00 0A.
  - Final State=127, IROut=0x00000000.
- Load: RAM[0x80]=0xDEADBEEF; ld [%g0+0x80],%g3 -> r3=0xDEADBEEF; states 40,41,42.
- Branch with delay slot:
  - subcc %g1,%g1,%g0 sets Z=1.
  - be +3 -> delay-slot instruction executes, then PC = branch address+12.
  - Same sequence with bne -> falls through.
- Flags: r1=0x7FFFFFFF; addcc r1,1 -> N=1, V=1, Z=0, C=0.
- r0 write and mid-op reset:
  - or %g0,7,%g0 -> r0 stays 0.
  - Assert Clr in state 51 -> store suppressed; State=0 next cycle.
